// File: rtl/dmem_amo_seq.sv
// dmem_amo_seq: round-robin serializer for RV32A AMOs onto one shared dmem port.
// The winning core's read-modify-write runs as one indivisible sequence, and the core gets the old value back.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 14
`endif

module dmem_amo_seq #(
  parameter int NCORES     = `NCORES,
  parameter int DMEM_ADDRW = `DMEM_ADDRW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            req_packed_i,
  input  logic [4*NCORES-1:0]          op_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic [NCORES-1:0]            done_packed_o,
  output logic [NCORES-1:0]            stall_packed_o,
  output logic                         mem_re_o,
  output logic                         mem_we_o,
  output logic [DMEM_ADDRW-1:0]        mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_wstrb_o,
  input  logic                         mem_gnt_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         inval_valid_o,
  output logic [DMEM_ADDRW-1:0]        inval_addr_o,
  output logic                         busy_o
);

  localparam int SELW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [3:0] OP_SWAP = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_MIN  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MINU = 4'd7;
  localparam logic [3:0] OP_MAXU = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SELW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic [3:0]            op_q, op_d;
  logic [DMEM_ADDRW-1:0] addr_q, addr_d;
  logic [31:0]           opnd_q, opnd_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           new_q, new_d;
  logic [31:0]           rdata_q [NCORES];

  logic [3:0]            op_arr   [NCORES];
  logic [DMEM_ADDRW-1:0] addr_arr [NCORES];
  logic [31:0]           wd_arr   [NCORES];

  logic                  grant_vld;
  logic [SELW-1:0]       win_sel;
  logic                  hi_vld;
  logic [SELW-1:0]       hi_sel;
  logic [SELW-1:0]       lo_sel;

  function automatic logic [31:0] amo_alu(input logic [3:0]  op,
                                          input logic [31:0] mval,
                                          input logic [31:0] opnd);
    logic signed [31:0] ms;
    logic signed [31:0] os;
    logic [31:0]        res;
    ms = mval;
    os = opnd;
    case (op)
      OP_SWAP: res = opnd;
      OP_ADD:  res = mval + opnd;
      OP_XOR:  res = mval ^ opnd;
      OP_AND:  res = mval & opnd;
      OP_OR:   res = mval | opnd;
      OP_MIN:  res = (ms < os) ? mval : opnd;
      OP_MAX:  res = (ms > os) ? mval : opnd;
      OP_MINU: res = (mval < opnd) ? mval : opnd;
      OP_MAXU: res = (mval > opnd) ? mval : opnd;
      default: res = mval;
    endcase
    return res;
  endfunction

  function automatic logic amo_legal(input logic [3:0] op);
    return (op <= OP_MAXU);
  endfunction

  for (genvar g = 0; g < NCORES; g++) begin : g_core
    assign op_arr[g]   = op_packed_i[4*g +: 4];
    assign addr_arr[g] = addr_packed_i[DMEM_ADDRW*g +: DMEM_ADDRW];
    assign wd_arr[g]   = wdata_packed_i[32*g +: 32];
    // Completing core sees its old value in the DONE cycle, before rdata_q updates.
    assign rdata_packed_o[32*g +: 32] =
      (state_q == S_DONE && sel_q == SELW'(g)) ? old_q : rdata_q[g];
  end

  // Round-robin: lowest requester at or above rr_ptr, else lowest requester overall.
  always_comb begin
    grant_vld = 1'b0;
    hi_vld    = 1'b0;
    hi_sel    = '0;
    lo_sel    = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (req_packed_i[i]) begin
        grant_vld = 1'b1;
        lo_sel    = SELW'(i);
        if (SELW'(i) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_sel = SELW'(i);
        end
      end
    end
    win_sel = hi_vld ? hi_sel : lo_sel;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    sel_d         = sel_q;
    op_d          = op_q;
    addr_d        = addr_q;
    opnd_d        = opnd_q;
    old_d         = old_q;
    new_d         = new_q;
    mem_re_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_wstrb_o   = 4'h0;
    inval_valid_o = 1'b0;
    inval_addr_o  = '0;
    done_packed_o = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          sel_d    = win_sel;
          op_d     = op_arr[win_sel];
          addr_d   = addr_arr[win_sel];
          opnd_d   = wd_arr[win_sel];
          rr_ptr_d = (win_sel == SELW'(NCORES - 1)) ? '0 : win_sel + 1'b1;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        mem_re_o   = 1'b1;
        mem_addr_o = addr_q;
        if (mem_gnt_i) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        old_d   = mem_rdata_i;
        new_d   = amo_alu(op_q, mem_rdata_i, opnd_q);
        state_d = amo_legal(op_q) ? S_WR : S_DONE;
      end
      S_WR: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = new_q;
        mem_wstrb_o = 4'hF;
        if (mem_gnt_i) begin
          inval_valid_o = 1'b1;
          inval_addr_o  = addr_q;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        done_packed_o[sel_q] = 1'b1;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Operation context is only consumed under state qualification, so it carries no reset.
  always_ff @(posedge clk_i) begin
    sel_q  <= sel_d;
    op_q   <= op_d;
    addr_q <= addr_d;
    opnd_q <= opnd_d;
    old_q  <= old_d;
    new_q  <= new_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCORES; i++) rdata_q[i] <= '0;
    end else if (state_q == S_DONE) begin
      rdata_q[sel_q] <= old_q;
    end
  end

  assign stall_packed_o = req_packed_i & ~done_packed_o;
  assign busy_o         = (state_q != S_IDLE);

endmodule
